// File: rtl/sauria_demo_pkg.sv
// Shared SAURIA demo definitions: sequencer FSM states, error codes and the
// default status-register polling constants.
package sauria_demo_pkg;

    typedef enum logic [2:0] {
        SEQ_IDLE  = 3'd0,
        SEQ_WRITE = 3'd1,
        SEQ_POLL  = 3'd2,
        SEQ_DONE  = 3'd3,
        SEQ_ERROR = 3'd4
    } seq_state_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_BUS     = 2'd1,
        ERR_TIMEOUT = 2'd2
    } err_code_e;

    localparam logic [31:0] DefaultPollAddr = 32'h0000_0004;
    localparam logic [31:0] DefaultDoneMask = 32'h0000_0001;

endpackage

// File: rtl/sauria_desc_table.sv
// Descriptor store: one address/data pair per entry, single write port and
// an asynchronous read port. Contents deliberately survive reset.
module sauria_desc_table #(
    parameter int unsigned NumDesc   = 16,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32
) (
    input  logic                       clk_i,
    input  logic                       we_i,
    input  logic [$clog2(NumDesc)-1:0] widx_i,
    input  logic [AddrWidth-1:0]       waddr_i,
    input  logic [DataWidth-1:0]       wdata_i,
    input  logic [$clog2(NumDesc)-1:0] ridx_i,
    output logic [AddrWidth-1:0]       raddr_o,
    output logic [DataWidth-1:0]       rdata_o
);

    logic [AddrWidth-1:0] addr_q [NumDesc];
    logic [DataWidth-1:0] data_q [NumDesc];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            addr_q[widx_i] <= waddr_i;
            data_q[widx_i] <= wdata_i;
        end
    end

    assign raddr_o = addr_q[ridx_i];
    assign rdata_o = data_q[ridx_i];

endmodule

// File: rtl/sauria_cfg_sequencer.sv
// Register-bus master that replays the descriptor table into SAURIA, then
// polls its status register and raises a level interrupt on done or error.
module sauria_cfg_sequencer
    import sauria_demo_pkg::*;
#(
    parameter int unsigned          NumDesc   = 16,
    parameter int unsigned          AddrWidth = 32,
    parameter int unsigned          DataWidth = 32,
    parameter logic [AddrWidth-1:0] PollAddr  = AddrWidth'(DefaultPollAddr),
    parameter logic [DataWidth-1:0] DoneMask  = DataWidth'(DefaultDoneMask),
    parameter int unsigned          PollMax   = 1024
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         desc_we_i,
    input  logic [$clog2(NumDesc)-1:0]   desc_idx_i,
    input  logic [AddrWidth-1:0]         desc_addr_i,
    input  logic [DataWidth-1:0]         desc_data_i,
    input  logic                         start_i,
    input  logic [$clog2(NumDesc):0]     num_i,
    input  logic                         irq_clr_i,
    output logic                         busy_o,
    output logic                         irq_o,
    output logic [1:0]                   err_code_o,
    output logic [AddrWidth-1:0]         reg_addr_o,
    output logic                         reg_write_o,
    output logic [DataWidth-1:0]         reg_wdata_o,
    output logic [DataWidth/8-1:0]       reg_wstrb_o,
    output logic                         reg_valid_o,
    input  logic [DataWidth-1:0]         reg_rdata_i,
    input  logic                         reg_error_i,
    input  logic                         reg_ready_i
);

    localparam int unsigned IdxW = $clog2(NumDesc);
    localparam int unsigned NumW = IdxW + 1;
    localparam int unsigned CntW = $clog2(PollMax + 1);

    seq_state_e           state_q;
    err_code_e            err_q;
    logic [IdxW-1:0]      idx_q;
    logic [NumW-1:0]      num_q;
    logic [CntW-1:0]      poll_cnt_q;
    logic                 busy_q, irq_q, valid_q, write_q;
    logic [AddrWidth-1:0] addr_q;
    logic [DataWidth-1:0] wdata_q;

    logic                 start_ok, accept, last_write, poll_done;
    logic [IdxW-1:0]      rd_idx;
    logic [NumW-1:0]      num_clamped;
    logic [CntW-1:0]      poll_cnt_d;
    logic [AddrWidth-1:0] tbl_addr;
    logic [DataWidth-1:0] tbl_data;

    assign start_ok    = start_i && (state_q inside {SEQ_IDLE, SEQ_DONE, SEQ_ERROR});
    assign accept      = valid_q && reg_ready_i;
    assign num_clamped = (num_i > NumW'(NumDesc)) ? NumW'(NumDesc) : num_i;
    assign last_write  = ({1'b0, idx_q} == (num_q - 1'b1));
    assign poll_done   = ((reg_rdata_i & DoneMask) == DoneMask);
    assign poll_cnt_d  = poll_cnt_q + 1'b1;
    // Look one entry ahead so the next write is loaded in the acceptance cycle.
    assign rd_idx      = start_ok ? '0 : idx_q + 1'b1;

    sauria_desc_table #(
        .NumDesc  (NumDesc),
        .AddrWidth(AddrWidth),
        .DataWidth(DataWidth)
    ) i_desc_table (
        .clk_i  (clk_i),
        .we_i   (desc_we_i && !busy_q),
        .widx_i (desc_idx_i),
        .waddr_i(desc_addr_i),
        .wdata_i(desc_data_i),
        .ridx_i (rd_idx),
        .raddr_o(tbl_addr),
        .rdata_o(tbl_data)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= SEQ_IDLE;
            err_q      <= ERR_NONE;
            idx_q      <= '0;
            num_q      <= '0;
            poll_cnt_q <= '0;
            busy_q     <= 1'b0;
            irq_q      <= 1'b0;
            valid_q    <= 1'b0;
            write_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else if (start_ok) begin
            num_q      <= num_clamped;
            idx_q      <= '0;
            poll_cnt_q <= '0;
            busy_q     <= 1'b1;
            irq_q      <= 1'b0;
            err_q      <= ERR_NONE;
            valid_q    <= 1'b1;
            if (num_clamped == '0) begin
                state_q <= SEQ_POLL;
                write_q <= 1'b0;
                addr_q  <= PollAddr;
                wdata_q <= '0;
            end else begin
                state_q <= SEQ_WRITE;
                write_q <= 1'b1;
                addr_q  <= tbl_addr;
                wdata_q <= tbl_data;
            end
        end else begin
            case (state_q)
                SEQ_WRITE: begin
                    if (accept) begin
                        if (reg_error_i) begin
                            state_q <= SEQ_ERROR;
                            err_q   <= ERR_BUS;
                            irq_q   <= 1'b1;
                            busy_q  <= 1'b0;
                            valid_q <= 1'b0;
                            write_q <= 1'b0;
                        end else if (last_write) begin
                            state_q <= SEQ_POLL;
                            write_q <= 1'b0;
                            addr_q  <= PollAddr;
                            wdata_q <= '0;
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            addr_q  <= tbl_addr;
                            wdata_q <= tbl_data;
                        end
                    end
                end
                SEQ_POLL: begin
                    // The read stays valid across polls, so each acceptance reissues it.
                    if (accept) begin
                        if (reg_error_i) begin
                            state_q <= SEQ_ERROR;
                            err_q   <= ERR_BUS;
                            irq_q   <= 1'b1;
                            busy_q  <= 1'b0;
                            valid_q <= 1'b0;
                        end else if (poll_done) begin
                            state_q <= SEQ_DONE;
                            irq_q   <= 1'b1;
                            busy_q  <= 1'b0;
                            valid_q <= 1'b0;
                        end else begin
                            poll_cnt_q <= poll_cnt_d;
                            if (poll_cnt_d == CntW'(PollMax)) begin
                                state_q <= SEQ_ERROR;
                                err_q   <= ERR_TIMEOUT;
                                irq_q   <= 1'b1;
                                busy_q  <= 1'b0;
                                valid_q <= 1'b0;
                            end
                        end
                    end
                end
                SEQ_DONE, SEQ_ERROR: begin
                    if (irq_clr_i) begin
                        state_q <= SEQ_IDLE;
                        irq_q   <= 1'b0;
                        err_q   <= ERR_NONE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign irq_o       = irq_q;
    assign err_code_o  = err_q;
    assign reg_addr_o  = addr_q;
    assign reg_write_o = write_q;
    assign reg_wdata_o = wdata_q;
    assign reg_wstrb_o = '1;
    assign reg_valid_o = valid_q;

endmodule
